sim_run_sequencer: RTL and testbench
====================================

// Module: sim_run_sequencer
// PURPOSE
//   Sequences the simulated design under test (DUT) in the Icarus debug framework.
//   Stretches the post-reset hold, then drives run, watches done and flushes for a drain window.
//   Repeats for NUM_RUNS runs, then raises a sticky finish flag for the testbench to $finish on.
//   A watchdog ends a hung run. Sits between the testbench clock/reset generator and M_main.
// PARAMETERS
//   RST_CYCLES      4         cycles DUT reset is held after rst_n release (>=1)
//   DRAIN_CYCLES    16        extra cycles after done before run closes (0 allowed)
//   NUM_RUNS        1         back-to-back DUT runs before finish (1..255)
//   TIMEOUT_CYCLES  10000000  watchdog limit in RUN cycles; 0 disables watchdog
//   CW              32        cycle counter width; TIMEOUT_CYCLES < 2**CW
// PORTS
//   clk          in   1   simulation clock
//   rst_n        in   1   asynchronous active-low reset
//   core_done    in   1   DUT done flag (level)
//   core_reset   out  1   active-high reset to DUT
//   core_run     out  1   run enable to DUT
//   sim_finish   out  1   sticky: sequencing complete (normal or timeout)
//   sim_timeout  out  1   sticky: watchdog fired
//   busy         out  1   1 while not in a terminal state
//   run_index    out  8   index of current run, 0-based
//   cycle_count  out  CW  RUN-state cycles of current run, saturating
//   state        out  3   HOLD=0 RUN=1 DRAIN=2 DONE=3 TMO=4
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low (clk, rst_n).
// - All outputs are registered.
// - rst_n low asserts immediately and clears the block:
//   state=HOLD, core_reset=1, core_run=0, sim_finish=0, sim_timeout=0, busy=1,
//   run_index=0, cycle_count=0, hold counter=RST_CYCLES-1.
// - HOLD:
//   - core_reset=1, core_run=0.
//   - Lasts exactly RST_CYCLES rising edges after entry or rst_n release.
//   - Then core_reset<=0, core_run<=1, state<=RUN.
//   - core_done is ignored throughout HOLD.
// - RUN:
//   - cycle_count increments once per RUN cycle and saturates at 2**CW-1.
//   - core_done=1 sampled on an edge -> DRAIN, drain counter loaded with DRAIN_CYCLES.
//   - Otherwise, if TIMEOUT_CYCLES!=0 and cycle_count==TIMEOUT_CYCLES-1 -> TMO.
//   - core_done and timeout on the same edge: done wins.
// - DRAIN:
//   - core_run stays 1; cycle_count frozen. Lasts DRAIN_CYCLES+1 cycles.
//   - On exit, if run_index==NUM_RUNS-1 -> DONE.
//   - Otherwise run_index++, cycle_count<=0, core_reset<=1, core_run<=0, hold counter reloaded, state<=HOLD.
//   - Further core_done edges in DRAIN are ignored.
// - DONE (terminal): core_run=0, core_reset=1, sim_finish=1, busy=0.
// - TMO (terminal): same as DONE, plus sim_timeout=1.
// - Terminal states are left only by rst_n.
// - core_done glitching low during DRAIN or terminal states has no effect.
// - run_index never exceeds NUM_RUNS-1. cycle_count is held in terminal states for post-mortem.
// - Reset mid-operation (any state): asynchronous return to reset values; no finish pulse is produced.
// TESTING
// 1 RST_CYCLES=4, done tied 0 for 10 cycles after release -> core_reset=1 on edges 1-4,
//   core_run=1 from edge 4, state=RUN.
// 2 NUM_RUNS=1, DRAIN_CYCLES=2, done at RUN cycle 20 -> cycle_count=20,
//   DRAIN 3 cycles, then sim_finish=1, sim_timeout=0, busy=0.
// 3 TIMEOUT_CYCLES=50, done never -> TMO after 50 RUN cycles,
//   cycle_count=49, sim_finish=1, sim_timeout=1.
// 4 TIMEOUT_CYCLES=50, done first seen on the 50th RUN edge -> DRAIN entered, sim_timeout stays 0.
// 5 NUM_RUNS=3, done after 5 cycles each run -> three HOLD pulses of RST_CYCLES,
//   run_index 0,1,2, finish only after third drain.
// 6 rst_n pulsed low mid-DRAIN of run 1 -> core_reset=1 asynchronously,
//   run_index=0, sequence restarts, no sim_finish.

Source files
------------

// File: rtl/sim_run_sequencer.sv
// sim_run_sequencer: reset stretch, run, drain and finish sequencing for a simulated DUT with watchdog
module sim_run_sequencer #(
  parameter int RST_CYCLES     = 4,
  parameter int DRAIN_CYCLES   = 16,
  parameter int NUM_RUNS       = 1,
  parameter int TIMEOUT_CYCLES = 10000000,
  parameter int CW             = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          core_done,
  output logic          core_reset,
  output logic          core_run,
  output logic          sim_finish,
  output logic          sim_timeout,
  output logic          busy,
  output logic [7:0]    run_index,
  output logic [CW-1:0] cycle_count,
  output logic [2:0]    state
);
  typedef enum logic [2:0] {HOLD = 3'd0, RUN = 3'd1, DRAIN = 3'd2, DONE = 3'd3, TMO = 3'd4} state_e;
  localparam int HW = $clog2(RST_CYCLES + 2);
  localparam int DW = $clog2(DRAIN_CYCLES + 2);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(RST_CYCLES - 1);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] LAST_RUN = 8'(NUM_RUNS - 1);
  state_e state_q;
  logic [HW-1:0] hold_q;
  logic [DW-1:0] drain_q;
  logic [CW-1:0] cyc_q;
  logic [7:0] idx_q;
  logic rst_q, run_q, fin_q, tmo_q, busy_q;
  logic wd_hit;
  // watchdog fires on the RUN edge where the count already reached its last value; done takes priority
  assign wd_hit = (TIMEOUT_CYCLES != 0) && (cyc_q == TMO_LAST) && !core_done;
  // sequencer: all outputs are registered and move with the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HOLD;
      hold_q  <= HOLD_LOAD;
      drain_q <= '0;
      cyc_q   <= '0;
      idx_q   <= '0;
      rst_q   <= 1'b1;
      run_q   <= 1'b0;
      fin_q   <= 1'b0;
      tmo_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      case (state_q)
        HOLD:
          if (hold_q == '0) begin
            state_q <= RUN;
            rst_q   <= 1'b0;
            run_q   <= 1'b1;
          end else hold_q <= hold_q - 1'b1;
        RUN: begin
          if (!wd_hit && cyc_q != '1) cyc_q <= cyc_q + 1'b1;
          if (core_done) begin
            state_q <= DRAIN;
            drain_q <= DRAIN_LOAD;
          end else if (wd_hit) begin
            state_q <= TMO;
            rst_q   <= 1'b1;
            run_q   <= 1'b0;
            fin_q   <= 1'b1;
            tmo_q   <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        DRAIN:
          if (drain_q != '0) drain_q <= drain_q - 1'b1;
          else if (idx_q == LAST_RUN) begin
            state_q <= DONE;
            rst_q   <= 1'b1;
            run_q   <= 1'b0;
            fin_q   <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            state_q <= HOLD;
            hold_q  <= HOLD_LOAD;
            idx_q   <= idx_q + 1'b1;
            cyc_q   <= '0;
            rst_q   <= 1'b1;
            run_q   <= 1'b0;
          end
        default: ;
      endcase
    end
  end
  assign state       = state_q;
  assign core_reset  = rst_q;
  assign core_run    = run_q;
  assign sim_finish  = fin_q;
  assign sim_timeout = tmo_q;
  assign busy        = busy_q;
  assign run_index   = idx_q;
  assign cycle_count = cyc_q;
endmodule

// File: tb/tb_sim_run_sequencer.sv
// tb_sim_run_sequencer: directed checks of hold, run, drain, watchdog, multi-run and async reset
module tb_sim_run_sequencer;
  localparam int CW = 8;
  localparam logic [2:0] S_HOLD = 3'd0, S_RUN = 3'd1, S_DRAIN = 3'd2, S_DONE = 3'd3, S_TMO = 3'd4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic core_done = 1'b0;
  logic core_reset, core_run, sim_finish, sim_timeout, busy;
  logic [7:0] run_index;
  logic [CW-1:0] cycle_count;
  logic [2:0] state;
  int n_vec = 0;
  int n_err = 0;
  sim_run_sequencer #(
    .RST_CYCLES(4), .DRAIN_CYCLES(2), .NUM_RUNS(3), .TIMEOUT_CYCLES(50), .CW(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .core_done(core_done), .core_reset(core_reset),
    .core_run(core_run), .sim_finish(sim_finish), .sim_timeout(sim_timeout), .busy(busy),
    .run_index(run_index), .cycle_count(cycle_count), .state(state)
  );
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL global_time_limit: observed no end expected end");
    $fatal(1, "time limit");
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [2:0] st, input logic rs, input logic rn,
                         input logic fi, input logic to, input logic bz, input logic [7:0] ix,
                         input logic [CW-1:0] cc);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".core_reset"}, 32'(core_reset), 32'(rs));
    chk({tag, ".core_run"}, 32'(core_run), 32'(rn));
    chk({tag, ".sim_finish"}, 32'(sim_finish), 32'(fi));
    chk({tag, ".sim_timeout"}, 32'(sim_timeout), 32'(to));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
    chk({tag, ".run_index"}, 32'(run_index), 32'(ix));
    chk({tag, ".cycle_count"}, 32'(cycle_count), 32'(cc));
  endtask
  task automatic hold_phase(input logic [7:0] idx);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i < 4) chk_all("hold", S_HOLD, 1, 0, 0, 0, 1, idx, 0);
      else chk_all("hold_exit", S_RUN, 0, 1, 0, 0, 1, idx, 0);
    end
  endtask
  task automatic run_once(input int k, input logic [7:0] idx, input bit last);
    hold_phase(idx);
    for (int i = 1; i < k; i++) begin
      tick();
      chk("run.state", 32'(state), 32'(S_RUN));
      chk("run.count", 32'(cycle_count), i);
    end
    core_done = 1'b1;
    tick();
    chk_all("drain_entry", S_DRAIN, 0, 1, 0, 0, 1, idx, CW'(k));
    for (int i = 1; i <= 3; i++) begin
      core_done = i[0];
      tick();
      if (i < 3) chk_all("drain", S_DRAIN, 0, 1, 0, 0, 1, idx, CW'(k));
      else if (last) chk_all("done", S_DONE, 1, 0, 1, 0, 0, idx, CW'(k));
      else chk_all("next_hold", S_HOLD, 1, 0, 0, 0, 1, idx + 8'd1, 0);
    end
    core_done = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    chk_all("reset", S_HOLD, 1, 0, 0, 0, 1, 0, 0);
    rst_n = 1'b1;
    hold_phase(0);
    for (int i = 1; i <= 10; i++) tick();
    chk_all("run10", S_RUN, 0, 1, 0, 0, 1, 0, 10);
    for (int i = 11; i <= 49; i++) tick();
    chk_all("run49", S_RUN, 0, 1, 0, 0, 1, 0, 49);
    tick();
    chk_all("timeout", S_TMO, 1, 0, 1, 1, 0, 0, 49);
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
    chk_all("tmo_sticky", S_TMO, 1, 0, 1, 1, 0, 0, 49);
    rst_n = 1'b0;
    #1;
    chk_all("tmo_reset", S_HOLD, 1, 0, 0, 0, 1, 0, 0);
    tick();
    rst_n = 1'b1;
    run_once(50, 0, 0);
    hold_phase(1);
    for (int i = 1; i < 5; i++) tick();
    core_done = 1'b1;
    tick();
    chk_all("r1_drain", S_DRAIN, 0, 1, 0, 0, 1, 1, 5);
    core_done = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("mid_drain_reset", S_HOLD, 1, 0, 0, 0, 1, 0, 0);
    tick();
    tick();
    chk_all("held_in_reset", S_HOLD, 1, 0, 0, 0, 1, 0, 0);
    rst_n = 1'b1;
    run_once(20, 0, 0);
    run_once(5, 1, 0);
    run_once(5, 2, 1);
    core_done = 1'b1;
    tick();
    tick();
    core_done = 1'b0;
    tick();
    chk_all("done_sticky", S_DONE, 1, 0, 1, 0, 0, 2, 5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
